// File: rtl/mul_div_pkg.sv
`default_nettype none
// ============================================================================
// mul_div_pkg : shared types and helpers for the shift-add multiplier/divider
// Revision    : 1.0
// ============================================================================
package mul_div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ITER  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } div_state_t;

    // Magnitude of a signed value, one bit wider so |most-negative| fits.
    function automatic logic [32:0] abs_ext(input logic [31:0] v);
        logic [32:0] e;
        e = {v[31], v};
        return e[32] ? (~e + 33'd1) : e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_control_datapath_if.sv
`default_nettype none
// ============================================================================
// div_control_datapath_if : Run/operand/result bundle of the divider
// Revision                : 1.0
// ============================================================================
interface div_control_datapath_if #(
    parameter int WIDTH = 8
);
    logic             Run;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic             Ovf;

    modport master (
        output Run, Dividend, Divisor,
        input  Quotient, Remainder, Busy, Done, DivZero, Ovf
    );

    modport slave (
        input  Run, Dividend, Divisor,
        output Quotient, Remainder, Busy, Done, DivZero, Ovf
    );
endinterface
`default_nettype wire

// File: rtl/div_datapath.sv
`default_nettype none
// ============================================================================
// div_datapath : restoring-divide R/Q registers, trial subtractor, sign fixup
// Revision     : 1.0
// ============================================================================
module div_datapath
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic             Clk,
    input  wire logic             Reset,
    input  wire logic             i_ld,
    input  wire logic             i_clr,
    input  wire logic             i_step,
    input  wire logic             i_fix,
    input  wire logic             i_dz,
    input  wire logic [WIDTH-1:0] i_dividend,
    input  wire logic [WIDTH-1:0] i_divisor,
    output logic                  o_divisor_zero,
    output logic      [WIDTH-1:0] o_quotient,
    output logic      [WIDTH-1:0] o_remainder,
    output logic                  o_div_zero,
    output logic                  o_ovf
);
    localparam logic [WIDTH-1:0] c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_abs_v;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_div_zero;
    logic             r_ovf;

    logic [WIDTH-1:0] w_abs_d;
    logic [WIDTH:0]   w_abs_v;
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;
    logic             w_ovf;

    assign w_abs_d = WIDTH'(abs_ext(32'($signed(r_dvd))));
    assign w_abs_v = (WIDTH+1)'(abs_ext(32'($signed(r_dvs))));

    // Extra guard bit on the trial difference gives the borrow as its sign.
    always_comb begin
        w_shift = {r_rem, r_q[WIDTH-1]};
        w_trial = w_shift - {1'b0, r_abs_v};
        w_ge    = ~w_trial[WIDTH+1];
        w_q_fix = r_sign_q ? (~r_q + 1'b1) : r_q;
        w_r_fix = r_sign_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
        w_ovf   = (r_dvd == c_MOST_NEG) && (r_dvs == '1);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_abs_v    <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_quot     <= '0;
            r_remo     <= '0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (i_ld) begin
                r_dvd      <= i_dividend;
                r_dvs      <= i_divisor;
                r_div_zero <= 1'b0;
                r_ovf      <= 1'b0;
            end
            if (i_clr) begin
                r_rem    <= '0;
                r_q      <= w_abs_d;
                r_abs_v  <= w_abs_v;
                r_sign_q <= r_dvd[WIDTH-1] ^ r_dvs[WIDTH-1];
                r_sign_r <= r_dvd[WIDTH-1];
            end
            if (i_dz) begin
                r_quot     <= '1;
                r_remo     <= r_dvd;
                r_div_zero <= 1'b1;
            end
            if (i_step) begin
                r_rem <= w_ge ? (WIDTH+1)'(w_trial) : (WIDTH+1)'(w_shift);
                r_q   <= {r_q[WIDTH-2:0], w_ge};
            end
            if (i_fix) begin
                r_quot <= w_ovf ? c_MOST_NEG : w_q_fix;
                r_remo <= w_ovf ? '0 : w_r_fix;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign o_divisor_zero = (r_dvs == '0);
    assign o_quotient     = r_quot;
    assign o_remainder    = r_remo;
    assign o_div_zero     = r_div_zero;
    assign o_ovf          = r_ovf;

endmodule
`default_nettype wire

// File: rtl/div_control_datapath.sv
`default_nettype none
// ============================================================================
// div_control_datapath : sequential signed restoring divider, one bit per clock
// Revision             : 1.0
// ============================================================================
module div_control_datapath
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic           Clk,
    input  wire logic           Reset,
    div_control_datapath_if.slave bus
);
    localparam int c_CW = $clog2(WIDTH);

    div_state_t      r_state;
    div_state_t      w_next;
    logic [c_CW-1:0] r_count;

    logic w_ld;
    logic w_clr;
    logic w_step;
    logic w_fix;
    logic w_dz;
    logic w_divisor_zero;
    logic w_busy;
    logic w_done;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_count <= (r_state == ITER) ? r_count + 1'b1 : '0;
        end
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = bus.Run ? LOAD : IDLE;
            LOAD:    w_next = w_divisor_zero ? DONE : ITER;
            ITER:    w_next = (r_count == c_CW'(WIDTH-1)) ? FIXUP : ITER;
            FIXUP:   w_next = DONE;
            DONE:    w_next = bus.Run ? DONE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_ld   = (r_state == IDLE) && bus.Run;
        w_clr  = (r_state == LOAD) && !w_divisor_zero;
        w_dz   = (r_state == LOAD) && w_divisor_zero;
        w_step = (r_state == ITER);
        w_fix  = (r_state == FIXUP);
        w_busy = (r_state == LOAD) || (r_state == ITER) || (r_state == FIXUP);
        w_done = (r_state == DONE);
    end

    div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .Clk            (Clk),
        .Reset          (Reset),
        .i_ld           (w_ld),
        .i_clr          (w_clr),
        .i_step         (w_step),
        .i_fix          (w_fix),
        .i_dz           (w_dz),
        .i_dividend     (bus.Dividend),
        .i_divisor      (bus.Divisor),
        .o_divisor_zero (w_divisor_zero),
        .o_quotient     (bus.Quotient),
        .o_remainder    (bus.Remainder),
        .o_div_zero     (bus.DivZero),
        .o_ovf          (bus.Ovf)
    );

    assign bus.Busy = w_busy;
    assign bus.Done = w_done;

endmodule
`default_nettype wire
